// File: rtl/irq_arbiter.sv
// Interrupt arbiter: rising-edge capture into a pending register, one grant at a time to the core.
// Grant order is round-robin by default; define IRQ_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] irq_ack_o,
  output logic [N_SRC-1:0] pending_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e           r_state;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_ack;
  logic             r_req;
  logic [ID_W-1:0]  r_id;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic [ID_W-1:0]  w_win;
  logic             w_found;

  assign w_rise = irq_src_i & ~r_src_q;
  assign w_elig = r_pending & irq_mask_i;

`ifdef IRQ_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!w_found && w_elig[i[ID_W-1:0]]) begin
        w_win   = ID_W'(i);
        w_found = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] r_rr_ptr;
  int unsigned     w_idx;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_idx = (32'(r_rr_ptr) + i) % N_SRC;
      if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
        w_win   = w_idx[ID_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (r_state == BUSY && irq_ret_i) begin
      r_rr_ptr <= (r_id == ID_W'(N_SRC - 1)) ? '0 : r_id + ID_W'(1);
    end
  end
`endif

  always_comb begin
    w_clr = '0;
    if (r_state == BUSY && irq_ret_i) w_clr[r_id] = 1'b1;
  end

  // Edge history resets to all-ones so lines already high at reset release are not taken as events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_src_q   <= '1;
      r_pending <= '0;
      r_ack     <= '0;
      r_req     <= 1'b0;
      r_id      <= '0;
    end else begin
      r_src_q   <= irq_src_i;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      unique case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_found) begin
            r_id    <= w_win;
            r_req   <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (irq_ret_i) begin
            r_req   <= 1'b0;
            r_ack   <= w_clr;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_req_o = r_req;
  assign irq_id_o  = r_id;
  assign irq_ack_o = r_ack;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter (N_SRC=8): directed scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural model of the arbitration rules.
module tb_irq_arbiter;
  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] irq_src_i;
  logic [N-1:0] irq_mask_i;
  logic         irq_ret_i;
  logic         irq_req_o;
  logic [2:0]   irq_id_o;
  logic [N-1:0] irq_ack_o;
  logic [N-1:0] pending_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .irq_src_i (irq_src_i),
    .irq_mask_i(irq_mask_i),
    .irq_ret_i (irq_ret_i),
    .irq_req_o (irq_req_o),
    .irq_id_o  (irq_id_o),
    .irq_ack_o (irq_ack_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = no grant, 1 = granted, 2 = post-return gap cycle.
  logic [N-1:0] m_pend, m_prev, m_ack, m_rise;
  logic         m_req;
  int           m_id, m_ptr, m_phase, m_w, m_clr;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pend = '0; m_prev = '1; m_ack = '0; m_req = 1'b0;
      m_id = 0; m_ptr = 0; m_phase = 0;
    end else begin
      m_rise = irq_src_i & ~m_prev;
      m_prev = irq_src_i;
      m_clr  = -1;
      if (m_phase == 0) begin
        m_w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
`ifdef IRQ_ARB_FIXED_PRIO_EN
          j = k;
`else
          j = (m_ptr + k) % N;
`endif
          if (m_w < 0 && m_pend[j] && irq_mask_i[j]) m_w = j;
        end
        m_ack = '0;
        if (m_w >= 0) begin
          m_req = 1'b1; m_id = m_w; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (irq_ret_i) begin
          m_clr = m_id;
          m_req = 1'b0;
          m_ack = '0;
          m_ack[m_id] = 1'b1;
          m_ptr = (m_id + 1) % N;
          m_phase = 2;
        end
      end else begin
        m_ack = '0;
        m_phase = 0;
      end
      if (m_clr >= 0) m_pend[m_clr] = 1'b0;
      m_pend = m_pend | m_rise;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("cyc_req", irq_req_o, m_req);
      check("cyc_ack", irq_ack_o, m_ack);
      check("cyc_pend", pending_o, m_pend);
      if (m_req) check("cyc_id", irq_id_o, m_id);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, irq_req_o, 1);
  endtask

  task automatic serve(input logic [2:0] exp_id, input string tag);
    logic [N-1:0] one_hot;
    one_hot = '0;
    one_hot[exp_id] = 1'b1;
    wait_req(tag);
    check({tag, "_id"}, irq_id_o, exp_id);
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    check({tag, "_ack"}, irq_ack_o, one_hot);
    check({tag, "_req_drop"}, irq_req_o, 0);
    tick();
    check({tag, "_ack_end"}, irq_ack_o, 0);
    check({tag, "_req_gap"}, irq_req_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; irq_src_i = '1; irq_mask_i = 8'hFF; irq_ret_i = 1'b0;
    #12;
    check("rst_req", irq_req_o, 0);
    check("rst_id", irq_id_o, 0);
    check("rst_ack", irq_ack_o, 0);
    check("rst_pend", pending_o, 0);
    tick();
    rst_ni = 1'b1;
    tick(3);
    check("rel_high_req", irq_req_o, 0);
    check("rel_high_pend", pending_o, 0);
    irq_src_i = '0;
    tick();

    // Round-robin: 1 and 5 together, twice; pointer wraps back to 1.
    irq_src_i = 8'h22;
    tick();
    check("rr_pend", pending_o, 8'h22);
    serve(3'd1, "rr_a1");
    serve(3'd5, "rr_a5");
    irq_src_i = '0;
    tick();
    irq_src_i = 8'h22;
    tick();
    serve(3'd1, "rr_b1");
    serve(3'd5, "rr_b5");
    irq_src_i = '0;
    tick();

    // Single source latency: rise in cycle t, request visible after posedge t+1.
    irq_src_i = 8'h08;
    tick();
    check("single_pend", pending_o, 8'h08);
    check("single_noreq", irq_req_o, 0);
    tick();
    check("single_req", irq_req_o, 1);
    check("single_id", irq_id_o, 3);
    tick(3);
    check("single_hold", irq_req_o, 1);
    serve(3'd3, "single");
    check("single_clr", pending_o, 0);
    tick();
    check("single_gap2", irq_req_o, 0);
    irq_src_i = '0;
    tick();

    // Masked source stays pending until unmasked.
    irq_mask_i = 8'h00;
    irq_src_i = 8'h04;
    tick(4);
    check("mask_pend", pending_o, 8'h04);
    check("mask_noreq", irq_req_o, 0);
    irq_mask_i = 8'h04;
    tick();
    check("unmask_req", irq_req_o, 1);
    check("unmask_id", irq_id_o, 2);
    irq_mask_i = 8'hFF;
    serve(3'd2, "unmask");
    irq_src_i = '0;
    tick();

    // Collision: new edge on the granted source in the return cycle.
    irq_src_i = 8'h10;
    tick();
    irq_src_i = 8'h00;
    wait_req("col");
    check("col_id", irq_id_o, 4);
    irq_ret_i = 1'b1;
    irq_src_i = 8'h10;
    tick();
    irq_ret_i = 1'b0;
    check("col_ack", irq_ack_o, 8'h10);
    check("col_pend", pending_o, 8'h10);
    tick();
    check("col_gap", irq_req_o, 0);
    tick();
    check("col_regrant", irq_req_o, 1);
    check("col_reid", irq_id_o, 4);
    serve(3'd4, "col2");
    irq_src_i = '0;
    tick();

    // Asynchronous reset while a grant is held.
    irq_src_i = 8'h01;
    tick();
    irq_src_i = 8'h00;
    wait_req("ar");
    check("ar_id", irq_id_o, 0);
    #3;
    rst_ni = 1'b0;
    #1;
    check("ar_req", irq_req_o, 0);
    check("ar_pend", pending_o, 0);
    check("ar_ack", irq_ack_o, 0);
    tick();
    rst_ni = 1'b1;
    tick(2);
    check("ar_post_req", irq_req_o, 0);
    check("ar_post_ack", irq_ack_o, 0);
    check("ar_post_pend", pending_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
